store_commit_unit: RTL and testbench

Multi-lane successor to the single-port store commit pipeline. It drains up to WRITE_LANES committed stores per cycle from the store queue head into the DCache and the IO unit. Stores move as an in-order group through three stages: SQ (read entry, request), Tag (hit/miss check, miss handling through the MSHR) and Data (IO write, SQ release). It sits between the commit stage, the store queue, the DCache write ports and the IO unit.

---
 rtl/store_commit_unit.sv | 214 +++++++++++++++++++++
 tb/tb_store_commit_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : store_commit_unit
// Brief   : Drains committed stores from the SQ head into DCache/IO lanes.
// Rev     : 1.0
// ============================================================================
module store_commit_unit #(
    parameter int SQ_ENTRY_NUM = 16,
    parameter int WRITE_LANES  = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int MSHR_NUM     = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    localparam int CW = $clog2(COMMIT_WIDTH + 1),
    localparam int QW = $clog2(SQ_ENTRY_NUM),
    localparam int LW = $clog2(WRITE_LANES + 1),
    localparam int BW = DATA_WIDTH / 8,
    localparam int MW = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    commit_store,
    input  logic [CW-1:0]                           commit_store_num,
    input  logic                                    to_recovery,
    output logic                                    busy_in_recovery,
    input  logic [QW-1:0]                           sq_head_ptr,
    output logic [QW-1:0]                           retired_ptr,
    input  logic [WRITE_LANES-1:0]                  ret_cond_en,
    input  logic [WRITE_LANES-1:0]                  ret_is_io,
    input  logic [WRITE_LANES-1:0][ADDR_WIDTH-1:0]  ret_addr,
    input  logic [WRITE_LANES-1:0][DATA_WIDTH-1:0]  ret_data,
    input  logic [WRITE_LANES-1:0][BW-1:0]          ret_be,
    output logic [WRITE_LANES-1:0]                  dc_write_req,
    output logic [WRITE_LANES-1:0][ADDR_WIDTH-1:0]  dc_write_addr,
    output logic [WRITE_LANES-1:0][DATA_WIDTH-1:0]  dc_write_data,
    output logic [WRITE_LANES-1:0][BW-1:0]          dc_write_be,
    input  logic [WRITE_LANES-1:0]                  dc_write_ack,
    input  logic [WRITE_LANES-1:0]                  dc_write_hit,
    input  logic [WRITE_LANES-1:0]                  dc_mshr_alloc,
    input  logic [WRITE_LANES-1:0][MW-1:0]          dc_mshr_id,
    input  logic [MSHR_NUM-1:0]                     mshr_write_done,
    output logic                                    io_we,
    output logic [ADDR_WIDTH-1:0]                   io_addr,
    output logic [DATA_WIDTH-1:0]                   io_data,
    output logic                                    release_head,
    output logic [LW-1:0]                           release_num,
    output logic [LW-1:0]                           perf_store_miss
);

    localparam int UW = $clog2(SQ_ENTRY_NUM + 1);

    typedef enum logic [0:0] {
        ST_COMMIT  = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t                                 r_state;
    state_t                                 w_state_next;
    logic [UW-1:0]                          r_unfinished;

    logic [WRITE_LANES-1:0]                 r_tag_valid;
    logic [WRITE_LANES-1:0]                 r_tag_cond;
    logic [WRITE_LANES-1:0]                 r_tag_io;
    logic [WRITE_LANES-1:0]                 r_tag_done;
    logic [WRITE_LANES-1:0]                 r_tag_mshr_vld;
    logic [WRITE_LANES-1:0][MW-1:0]         r_tag_mshr_id;
    logic [WRITE_LANES-1:0][ADDR_WIDTH-1:0] r_tag_addr;
    logic [WRITE_LANES-1:0][DATA_WIDTH-1:0] r_tag_data;
    logic [WRITE_LANES-1:0][BW-1:0]         r_tag_be;

    logic [WRITE_LANES-1:0]                 r_data_valid;
    logic                                   r_data_io0;
    logic                                   r_data_cond0;
    logic [ADDR_WIDTH-1:0]                  r_data_addr0;
    logic [DATA_WIDTH-1:0]                  r_data_data0;

    logic [WRITE_LANES-1:0]                 w_lane_done;
    logic [WRITE_LANES-1:0]                 w_tag_req;
    logic [WRITE_LANES-1:0]                 w_mshr_fin;
    logic [WRITE_LANES-1:0]                 w_sq_req;
    logic [WRITE_LANES-1:0]                 w_issue;
    logic                                   w_stall;
    logic [LW-1:0]                          w_issue_num;
    logic [LW-1:0]                          w_tag_cnt;
    logic [LW-1:0]                          w_data_cnt;
    logic [LW-1:0]                          w_miss_cnt;
    logic [UW-1:0]                          w_commit_add;

    always_comb begin
        w_state_next = to_recovery ? ST_RECOVER : ST_COMMIT;
    end

    // A lane that already owns an MSHR ignores hit and waits for its line write.
    always_comb begin
        w_lane_done = '0;
        w_tag_req   = '0;
        w_mshr_fin  = '0;
        for (int i = 0; i < WRITE_LANES; i++) begin
            w_mshr_fin[i]  = r_tag_valid[i] && r_tag_mshr_vld[i] && !r_tag_done[i]
                             && mshr_write_done[r_tag_mshr_id[i]];
            w_lane_done[i] = !r_tag_valid[i] || r_tag_done[i] || !r_tag_cond[i] || r_tag_io[i]
                             || (!r_tag_mshr_vld[i] && dc_write_hit[i]) || w_mshr_fin[i];
            w_tag_req[i]   = !w_lane_done[i] && !r_tag_mshr_vld[i];
        end
        w_stall = !(&w_lane_done);
    end

    // Group is the longest candidate prefix in which every requesting lane was acked.
    always_comb begin
        logic v_open;
        logic v_acked;
        v_open   = !w_stall;
        v_acked  = 1'b1;
        w_sq_req = '0;
        w_issue  = '0;
        for (int i = 0; i < WRITE_LANES; i++) begin
            v_open      = v_open && (i < int'(r_unfinished)) && !((i != 0) && ret_is_io[i]);
            w_sq_req[i] = v_open && ret_cond_en[i] && !ret_is_io[i];
            v_acked     = v_acked && (!w_sq_req[i] || dc_write_ack[i]);
            w_issue[i]  = v_open && v_acked;
        end
    end

    always_comb begin
        w_issue_num = '0;
        w_tag_cnt   = '0;
        w_data_cnt  = '0;
        w_miss_cnt  = '0;
        for (int i = 0; i < WRITE_LANES; i++) begin
            w_issue_num = w_issue_num + LW'(w_issue[i]);
            w_tag_cnt   = w_tag_cnt   + LW'(r_tag_valid[i]);
            w_data_cnt  = w_data_cnt  + LW'(r_data_valid[i]);
            w_miss_cnt  = w_miss_cnt  + LW'(w_mshr_fin[i]);
        end
        w_commit_add = commit_store ? UW'(commit_store_num) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_COMMIT;
            r_unfinished   <= '0;
            r_tag_valid    <= '0;
            r_tag_done     <= '0;
            r_tag_mshr_vld <= '0;
            r_data_valid   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_unfinished <= r_unfinished + w_commit_add - UW'(w_issue_num);
            r_data_valid <= w_stall ? '0 : r_tag_valid;
            if (!w_stall) begin
                r_tag_valid    <= w_issue;
                r_tag_done     <= '0;
                r_tag_mshr_vld <= '0;
            end else begin
                r_tag_done <= r_tag_done | w_lane_done;
                for (int i = 0; i < WRITE_LANES; i++) begin
                    if (!w_lane_done[i] && !r_tag_mshr_vld[i] && dc_mshr_alloc[i]) begin
                        r_tag_mshr_vld[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r_tag_cond   <= ret_cond_en;
            r_tag_io     <= ret_is_io;
            r_tag_addr   <= ret_addr;
            r_tag_data   <= ret_data;
            r_tag_be     <= ret_be;
            r_data_io0   <= r_tag_io[0];
            r_data_cond0 <= r_tag_cond[0];
            r_data_addr0 <= r_tag_addr[0];
            r_data_data0 <= r_tag_data[0];
        end else begin
            for (int i = 0; i < WRITE_LANES; i++) begin
                if (!w_lane_done[i] && !r_tag_mshr_vld[i] && dc_mshr_alloc[i]) begin
                    r_tag_mshr_id[i] <= dc_mshr_id[i];
                end
            end
        end
    end

    // While stalled the write ports carry the Tag-stage retries instead of new stores.
    always_comb begin
        dc_write_req  = rst ? '0 : (w_stall ? w_tag_req : w_sq_req);
        dc_write_addr = w_stall ? r_tag_addr : ret_addr;
        dc_write_data = w_stall ? r_tag_data : ret_data;
        dc_write_be   = w_stall ? r_tag_be   : ret_be;
    end

    assign busy_in_recovery = !rst && (r_state == ST_RECOVER);
    assign retired_ptr      = sq_head_ptr + QW'(w_tag_cnt) + QW'(w_data_cnt);
    assign io_we            = !rst && r_data_valid[0] && r_data_io0 && r_data_cond0;
    assign io_addr          = r_data_addr0;
    assign io_data          = r_data_data0;
    assign release_head     = !rst && (|r_data_valid);
    assign release_num      = rst ? '0 : w_data_cnt;
    assign perf_store_miss  = rst ? '0 : w_miss_cnt;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_unfinished <= UW'(SQ_ENTRY_NUM))
                else $error("store_commit_unit: unfinished counter overflow");
            assert (!((r_state == ST_RECOVER) && commit_store && (commit_store_num != '0)))
                else $error("store_commit_unit: store commit during recovery");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_commit_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_store_commit_unit
// Brief   : Directed scoreboard bench for store_commit_unit (2 lanes, 16-entry SQ).
// Rev     : 1.0
// ============================================================================
module tb_store_commit_unit;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              commit_store;
    logic [1:0]        commit_store_num;
    logic              to_recovery;
    logic              busy_in_recovery;
    logic [3:0]        sq_head_ptr;
    logic [3:0]        retired_ptr;
    logic [1:0]        ret_cond_en;
    logic [1:0]        ret_is_io;
    logic [1:0][31:0]  ret_addr;
    logic [1:0][63:0]  ret_data;
    logic [1:0][7:0]   ret_be;
    logic [1:0]        dc_write_req;
    logic [1:0][31:0]  dc_write_addr;
    logic [1:0][63:0]  dc_write_data;
    logic [1:0][7:0]   dc_write_be;
    logic [1:0]        dc_write_ack;
    logic [1:0]        dc_write_hit;
    logic [1:0]        dc_mshr_alloc;
    logic [1:0][0:0]   dc_mshr_id;
    logic [1:0]        mshr_write_done;
    logic              io_we;
    logic [31:0]       io_addr;
    logic [63:0]       io_data;
    logic              release_head;
    logic [1:0]        release_num;
    logic [1:0]        perf_store_miss;

    int n_checks = 0;
    int n_fail   = 0;
    int          exp_rel[$];
    logic [95:0] exp_io[$];

    store_commit_unit dut (
        .clk(clk), .rst(rst),
        .commit_store(commit_store), .commit_store_num(commit_store_num),
        .to_recovery(to_recovery), .busy_in_recovery(busy_in_recovery),
        .sq_head_ptr(sq_head_ptr), .retired_ptr(retired_ptr),
        .ret_cond_en(ret_cond_en), .ret_is_io(ret_is_io),
        .ret_addr(ret_addr), .ret_data(ret_data), .ret_be(ret_be),
        .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
        .dc_write_data(dc_write_data), .dc_write_be(dc_write_be),
        .dc_write_ack(dc_write_ack), .dc_write_hit(dc_write_hit),
        .dc_mshr_alloc(dc_mshr_alloc), .dc_mshr_id(dc_mshr_id),
        .mshr_write_done(mshr_write_done),
        .io_we(io_we), .io_addr(io_addr), .io_data(io_data),
        .release_head(release_head), .release_num(release_num),
        .perf_store_miss(perf_store_miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input logic cond, input logic io,
                            input logic [31:0] a, input logic [63:0] d);
        ret_cond_en[l] = cond;
        ret_is_io[l]   = io;
        ret_addr[l]    = a;
        ret_data[l]    = d;
        ret_be[l]      = 8'hFF;
    endtask

    function automatic logic [8:0] ctrl_outs();
        return {busy_in_recovery, dc_write_req, io_we, release_head, release_num, perf_store_miss};
    endfunction

    // Scoreboard: every release / IO write must match the oldest expectation.
    always @(negedge clk) begin
        if (release_head === 1'b1) begin
            if (exp_rel.size() == 0) begin
                check("sb_unexpected_release", {126'd0, release_num}, 128'd0);
            end else begin
                check("sb_release_num", {126'd0, release_num}, exp_rel.pop_front());
            end
        end
        if (io_we === 1'b1) begin
            if (exp_io.size() == 0) begin
                check("sb_unexpected_io", {96'd0, io_addr}, 128'd0);
            end else begin
                check("sb_io_addr_data", {32'd0, io_addr, io_data}, {32'd0, exp_io.pop_front()});
            end
        end
    end

    initial begin
        commit_store = 0; commit_store_num = 0; to_recovery = 0; sq_head_ptr = 4'd4;
        ret_cond_en = 0; ret_is_io = 0; ret_addr = '0; ret_data = '0; ret_be = '0;
        dc_write_ack = 2'b11; dc_write_hit = 2'b11; dc_mshr_alloc = 0; dc_mshr_id = '0;
        mshr_write_done = 0;
        set_lane(0, 1, 0, 32'h1000, 64'hA0); set_lane(1, 1, 0, 32'h1008, 64'hA1);

        // Reset
        repeat (3) tick();
        check("reset_outs", {119'd0, ctrl_outs()}, 128'd0);
        rst = 0;
        #1 check("post_reset_outs", {119'd0, ctrl_outs()}, 128'd0);
        check("post_reset_retired", {124'd0, retired_ptr}, 128'd4);
        tick();

        // Single store, hit
        commit_store = 1; commit_store_num = 1;
        tick(); commit_store = 0; commit_store_num = 0;
        #1 check("t1_req", {126'd0, dc_write_req}, 128'd1);
        check("t1_addr", {96'd0, dc_write_addr[0]}, 128'h1000);
        exp_rel.push_back(1);
        tick(); #1 check("t1_tag_req", {126'd0, dc_write_req}, 128'd0);
        check("t1_retired", {124'd0, retired_ptr}, 128'd5);
        tick(); #1 check("t1_release", {127'd0, release_head}, 128'd1);
        tick(); #1 check("t1_idle", {119'd0, ctrl_outs()}, 128'd0);

        // Two stores, one group
        commit_store = 1; commit_store_num = 2;
        tick(); commit_store = 0; commit_store_num = 0;
        #1 check("t2_req", {126'd0, dc_write_req}, 128'd3);
        check("t2_addr1", {96'd0, dc_write_addr[1]}, 128'h1008);
        exp_rel.push_back(2);
        tick(); tick(); #1 check("t2_release_num", {126'd0, release_num}, 128'd2);
        tick();

        // Cacheable then IO: IO truncates the group, then issues alone
        set_lane(1, 1, 1, 32'hF000_0010, 64'hBEEF);
        commit_store = 1; commit_store_num = 2;
        tick(); commit_store = 0; commit_store_num = 0;
        #1 check("t3_req", {126'd0, dc_write_req}, 128'd1);
        exp_rel.push_back(1);
        tick();
        set_lane(0, 1, 1, 32'hF000_0010, 64'hBEEF); set_lane(1, 0, 0, 32'h2008, 64'hB1);
        #1 check("t3_io_req", {126'd0, dc_write_req}, 128'd0);
        exp_rel.push_back(1); exp_io.push_back({32'hF000_0010, 64'hBEEF});
        tick(); set_lane(0, 1, 0, 32'h3000, 64'hC0); set_lane(1, 1, 0, 32'h3008, 64'hC1);
        tick(); #1 check("t3_io_we", {127'd0, io_we}, 128'd1);
        tick();

        // Lane 1 misses, MSHR alloc, write done 5 cycles later
        commit_store = 1; commit_store_num = 2;
        tick(); commit_store = 0; commit_store_num = 0;
        #1 check("t4_req", {126'd0, dc_write_req}, 128'd3);
        exp_rel.push_back(2);
        tick(); dc_write_hit = 2'b01; ret_addr[1] = 32'h9999;
        #1 check("t4_rereq", {126'd0, dc_write_req}, 128'd2);
        check("t4_rereq_addr", {96'd0, dc_write_addr[1]}, 128'h3008);
        tick(); dc_mshr_alloc = 2'b10; dc_mshr_id[1] = 1'b1;
        #1 check("t4_alloc_req", {126'd0, dc_write_req}, 128'd2);
        tick(); dc_mshr_alloc = 0; commit_store = 1; commit_store_num = 1;
        #1 check("t4_wait_req", {126'd0, dc_write_req}, 128'd0);
        check("t4_wait_retired", {124'd0, retired_ptr}, 128'd6);
        for (int k = 0; k < 3; k++) begin
            tick(); commit_store = 0; commit_store_num = 0;
            #1 check("t4_stall_outs", {119'd0, ctrl_outs()}, 128'd0);
        end
        tick(); mshr_write_done = 2'b10; set_lane(0, 1, 0, 32'h4000, 64'hD0);
        #1 check("t4_perf_miss", {126'd0, perf_store_miss}, 128'd1);
        check("t4_next_issue", {126'd0, dc_write_req}, 128'd1);
        exp_rel.push_back(1);
        tick(); mshr_write_done = 0; dc_write_hit = 2'b11;
        #1 check("t4_release", {127'd0, release_head}, 128'd1);
        check("t4_perf_clear", {126'd0, perf_store_miss}, 128'd0);
        tick(); tick();

        // retired_ptr wrap
        sq_head_ptr = 4'd15;
        commit_store = 1; commit_store_num = 2;
        tick(); commit_store = 0; commit_store_num = 0;
        #1 check("t5_ptr_sq", {124'd0, retired_ptr}, 128'd15);
        exp_rel.push_back(2);
        tick(); #1 check("t5_ptr_tag", {124'd0, retired_ptr}, 128'd1);
        tick(); #1 check("t5_ptr_data", {124'd0, retired_ptr}, 128'd1);
        tick(); #1 check("t5_ptr_idle", {124'd0, retired_ptr}, 128'd15);
        sq_head_ptr = 4'd4;

        // Recovery during a stall
        commit_store = 1; commit_store_num = 2;
        tick(); commit_store = 0; commit_store_num = 0;
        #1 exp_rel.push_back(2);
        tick(); dc_write_hit = 2'b01; dc_mshr_alloc = 2'b10; dc_mshr_id[1] = 1'b0;
        #1 check("t6_req", {126'd0, dc_write_req}, 128'd2);
        tick(); dc_mshr_alloc = 0; to_recovery = 1;
        #1 check("t6_busy_pre", {127'd0, busy_in_recovery}, 128'd0);
        tick(); to_recovery = 0;
        #1 check("t6_busy", {127'd0, busy_in_recovery}, 128'd1);
        check("t6_stall_rh", {127'd0, release_head}, 128'd0);
        tick(); mshr_write_done = 2'b01;
        #1 check("t6_busy_post", {127'd0, busy_in_recovery}, 128'd0);
        check("t6_perf_miss", {126'd0, perf_store_miss}, 128'd1);
        tick(); mshr_write_done = 0; dc_write_hit = 2'b11;
        #1 check("t6_release", {127'd0, release_head}, 128'd1);
        tick();

        // Reset in the middle of a stall drops the group
        commit_store = 1; commit_store_num = 2;
        tick(); commit_store = 0; commit_store_num = 0;
        #1 check("t7_req", {126'd0, dc_write_req}, 128'd3);
        tick(); dc_write_hit = 2'b01; dc_mshr_alloc = 2'b10; dc_mshr_id[1] = 1'b1;
        tick(); dc_mshr_alloc = 0; rst = 1;
        #1 check("t7_rst_outs", {119'd0, ctrl_outs()}, 128'd0);
        tick(); #1 check("t7_rst_outs2", {119'd0, ctrl_outs()}, 128'd0);
        tick(); rst = 0; dc_write_hit = 2'b11;
        #1 check("t7_after_rst", {119'd0, ctrl_outs()}, 128'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1 check("t7_no_release", {119'd0, ctrl_outs()}, 128'd0);
        end

        check("sb_rel_drained", 128'(exp_rel.size()), 128'd0);
        check("sb_io_drained", 128'(exp_io.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
